// File: rtl/mdu_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: op encodings,
// FSM states and the iteration count of the bit-serial core.
package mdu_pkg;
   localparam int XLEN       = 32;
   localparam int ITER_COUNT = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> multiply/divide unit handshake bundle.
interface mdu_sequencer_if;
   import mdu_pkg::*;
   logic            valid_in;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            flush;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output valid_in, op, rs1_val, rs2_val, flush,
                   input  stall, done, result);
   modport slave  (input  valid_in, op, rs1_val, rs2_val, flush,
                   output stall, done, result);
endinterface

// File: rtl/mdu_shift_core.sv
// One iteration of the bit-serial datapath: shift-add multiply step or
// restoring-divide step on a 64-bit {hi, lo} accumulator.
module mdu_shift_core
   import mdu_pkg::*;
(
   input  logic                div_i,
   input  logic [2*XLEN-1:0]   acc_i,
   input  logic [XLEN-1:0]     m_i,
   output logic [2*XLEN-1:0]   acc_o
);
   logic [XLEN:0] sum;
   logic [XLEN:0] diff;
   logic          qbit;

   // Multiply: lo holds the remaining multiplier bits, consumed from bit 0.
   assign sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, m_i} : '0);
   // Divide: the shifted partial remainder is 33 bits wide before the trial subtract.
   assign diff = acc_i[2*XLEN-1:XLEN-1] - {1'b0, m_i};
   assign qbit = ~diff[XLEN];

   always_comb begin
      acc_o = {sum, acc_i[XLEN-1:1]};
      if (div_i) begin
         if (qbit) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
         else      acc_o = {acc_i[2*XLEN-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/mdu_sequencer.sv
// Bit-serial RV32M multiply/divide unit: stalls the pipeline for 33 cycles
// per op (1 for divide-by-zero / signed overflow) and pulses done with the result.
module mdu_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic            flush,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);
   import mdu_pkg::*;

   state_e            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   opnd_q, opnd_d, result_q, result_d;
   logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
   logic              neg_q, neg_d, rneg_q, rneg_d;
   logic              stall_c, done_c;

   logic              is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, ovf;
   logic [XLEN-1:0]   a_mag, b_mag, special, quo, rem, fin;

   assign is_div   = op[2];
   assign sgn_a    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                     (op == OP_DIV) || (op == OP_REM);
   assign sgn_b    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign a_neg    = sgn_a & rs1_val[XLEN-1];
   assign b_neg    = sgn_b & rs2_val[XLEN-1];
   assign a_mag    = a_neg ? -rs1_val : rs1_val;
   assign b_mag    = b_neg ? -rs2_val : rs2_val;
   assign div_zero = is_div && (rs2_val == '0);
   assign ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                     (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
   // op[1] separates REM/REMU from DIV/DIVU.
   assign special  = div_zero ? (op[1] ? rs1_val : '1)
                              : (op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

   mdu_shift_core u_core (
      .div_i (op_q[2]),
      .acc_i (acc_q),
      .m_i   (opnd_q),
      .acc_o (acc_step)
   );

   assign prod = neg_q  ? -acc_step : acc_step;
   assign quo  = neg_q  ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
   assign rem  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

   always_comb begin
      fin = quo;
      case (op_q)
         OP_MUL:                        fin = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod[2*XLEN-1:XLEN];
         OP_REM, OP_REMU:               fin = rem;
         default:                       fin = quo;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      stall_c  = 1'b0;
      done_c   = 1'b0;
      case (state_q)
         IDLE: if (valid_in) begin
            stall_c = 1'b1;
            op_d    = op;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = '0;
            if (div_zero || ovf) begin
               result_d = special;
               state_d  = DONE;
            end else begin
               acc_d   = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
               opnd_d  = is_div ? b_mag : a_mag;
               state_d = BUSY;
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            acc_d   = acc_step;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'(ITER_COUNT-1)) begin
               result_d = fin;
               state_d  = DONE;
            end
         end
         DONE: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = result_q;
         stall_c  = 1'b0;
         done_c   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   // Reset must drop stall at once, even if EX still presents a request.
   assign stall  = rst & stall_c;
   assign done   = rst & done_c;
   assign result = result_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: results, stall/done timing, special
// cases, flush, mid-op reset and back-to-back issue.
module tb_mdu_sequencer;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;

   mdu_sequencer_if bif ();

   mdu_sequencer #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (bif.valid_in),
      .op       (bif.op),
      .rs1_val  (bif.rs1_val),
      .rs2_val  (bif.rs2_val),
      .flush    (bif.flush),
      .stall    (bif.stall),
      .done     (bif.done),
      .result   (bif.result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      bif.valid_in = 1'b1;
      bif.op       = o;
      bif.rs1_val  = a;
      bif.rs2_val  = b;
   endtask

   // Entered at a negedge with the request already driven; returns inside the done cycle.
   task automatic wait_done(input string tag, input logic [31:0] exp_res,
                            input int exp_stall, output int t_done);
      int  ns;
      bit  got;
      ns = 0;
      got = 1'b0;
      t_done = 0;
      for (int c = 1; c <= 60 && !got; c++) begin
         #1;
         if (bif.done) begin
            got = 1'b1;
            t_done = cyc;
            chk({tag, "_res"}, bif.result, exp_res);
            chk({tag, "_stall_cycles"}, ns, exp_stall);
            chk({tag, "_done_cycle"}, c, exp_stall + 1);
         end else begin
            if (bif.stall) ns++;
            @(negedge clk);
         end
      end
      if (!got) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
      int t;
      @(negedge clk);
      drive(o, a, b);
      wait_done(tag, exp_res, exp_stall, t);
      bif.valid_in = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, "_done_1cyc"}, bif.done, 0);
      chk({tag, "_idle_stall"}, bif.stall, 0);
   endtask

   task automatic watch_no_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         seen |= bif.done;
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      int t1, t2;
      bif.valid_in = 1'b1;
      bif.op       = OP_MUL;
      bif.rs1_val  = 32'd3;
      bif.rs2_val  = 32'd4;
      bif.flush    = 1'b0;
      #12;
      chk("rst_stall", bif.stall, 0);
      chk("rst_done", bif.done, 0);
      chk("rst_result", bif.result, 0);
      bif.valid_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_novalid_stall", bif.stall, 0);

      run_op("mul",    OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      #20;
      chk("result_hold", bif.result, 32'hFFFF_FFEB);
      run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_op("divu",   OP_DIVU,   32'd100,       32'd7,         32'd14,        33);
      run_op("remu",   OP_REMU,   32'd100,       32'd7,         32'd2,         33);
      run_op("div0",   OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem0",   OP_REM,    32'd5,         32'd0,         32'd5,         1);
      run_op("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

      // Flush while the counter is at 10 (11 cycles after the request cycle).
      @(negedge clk);
      drive(OP_DIVU, 32'd1000, 32'd7);
      repeat (11) @(negedge clk);
      #1;
      chk("flush_busy_stall", bif.stall, 1);
      bif.flush    = 1'b1;
      bif.valid_in = 1'b0;
      #1;
      chk("flush_cycle_stall", bif.stall, 0);
      @(negedge clk);
      bif.flush = 1'b0;
      #1;
      chk("flush_next_stall", bif.stall, 0);
      watch_no_done("flush_no_done");

      // Reset while the counter is at 20.
      @(negedge clk);
      drive(OP_DIVU, 32'd1000, 32'd7);
      repeat (21) @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_stall", bif.stall, 0);
      chk("midrst_result", bif.result, 0);
      @(negedge clk);
      rst = 1'b1;
      bif.valid_in = 1'b0;
      watch_no_done("midrst_no_done");
      run_op("divu_after", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

      // Back-to-back: next request presented during the done cycle.
      @(negedge clk);
      drive(OP_MUL, 32'd3, 32'd4);
      wait_done("b2b_first", 32'd12, 33, t1);
      drive(OP_MUL, 32'd5, 32'd6);
      @(negedge clk);
      wait_done("b2b_second", 32'd30, 33, t2);
      bif.valid_in = 1'b0;
      chk("b2b_spacing", t2 - t1, 34);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port valid_in  input  1  an RV32M op occupies EX (ALU control bit 4); held high while stall=1.
REQ-005 SHALL have port op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_val  input  32  forwarded operand A (multiplicand/dividend).
REQ-007 SHALL have port rs2_val  input  32  forwarded operand B (multiplier/divisor).
REQ-008 SHALL have port flush  input  1  EX-stage flush; aborts any operation in progress.
REQ-009 SHALL have port stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid this cycle.
REQ-011 SHALL have port result  output  32  final MUL/DIV/REM value.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 In IDLE, with valid_in=1 and flush=0: stall=1 combinationally; operands, op and sign flags latched; next state BUSY with iter counter 0.
REQ-014 Divide by zero SHALL skip BUSY and go IDLE->DONE: quotient 0xFFFFFFFF, remainder = rs1_val; stall=1 for 1 cycle.
REQ-015 Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF) SHALL skip BUSY: quotient 0x80000000, remainder 0; stall=1 for 1 cycle.
REQ-016 BUSY SHALL run exactly 32 iterations (counter 0..31), one bit per cycle: shift-add multiply of magnitudes into a 64-bit accumulator; restoring divide of magnitudes; stall=1 throughout.
REQ-017 Counter 31 SHALL transition BUSY->DONE; normal latency: stall high 33 cycles, done in the 34th cycle after the request cycle.
REQ-018 Sign rules SHALL apply: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; product negated when operand signs differ; quotient negative when signs differ; remainder takes the dividend's sign.
REQ-019 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-020 In DONE: stall=0, done=1, result driven; valid_in ignored; next state IDLE unconditionally.
REQ-021 result SHALL hold its last value until the next DONE.
REQ-022 flush=1 in any state SHALL force IDLE at the next edge with no done pulse; flush has priority over valid_in; stall SHALL be 0 in a cycle where flush=1.
REQ-023 A request arriving in the IDLE cycle right after DONE SHALL start normally (back-to-back supported).
REQ-024 valid_in=0 in IDLE SHALL keep stall=0 and done=0.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, counter 0, stall=0, done=0, result=0, accumulators 0, independent of clk.
REQ-026 Reset asserted mid-BUSY SHALL discard the operation; no done pulse after release.

Structure
REQ-027 Package mdu_pkg SHALL hold XLEN, the eight funct3 op encodings, the FSM state encoding and ITER_COUNT=32.
REQ-028 Sub-module mdu_shift_core SHALL implement one iteration step (64-bit shift, add/subtract, quotient bit); FSM, sign fix-up and special cases stay in mdu_sequencer.

Verification
REQ-029 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; stall high 33 cycles; done pulse exactly 1 cycle in cycle 34.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-032 DIV 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; each with 1 stall cycle and done in the next cycle.
REQ-033 Flush at counter 10 -> stall 0 next cycle, no done; rst low at counter 20 -> stall 0 immediately; a following DIVU 9/3 then returns 3 with normal latency.
REQ-034 Back-to-back MUL 3x4 then MUL 5x6 with valid_in high continuously -> two done pulses 34 cycles apart, results 12 then 30.
